// File: rtl/msu_pkg.sv
// MSU-1 shared types and register constants.
// Stream FSM states, status bit positions and ID string.
package msu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FILL,
    ST_STREAM
  } msu_state_e;

  localparam int DATA_BUSY  = 7;
  localparam int AUDIO_BUSY = 6;
  localparam int REPEAT     = 5;
  localparam int PLAYING    = 4;
  localparam int MISSING    = 3;

  localparam logic [2:0] MSU_REVISION = 3'b001;

  localparam logic [47:0] MSU_ID = "S-MSU1";

  // idx 0 is 'S', the first byte the decoder returns.
  function automatic logic [7:0] msu_id_byte(
    input logic [2:0] idx
  );
    if (idx > 3'd5) return 8'h00;
    return MSU_ID[8*(5-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/msu_data_stream_fifo.sv
// Byte FIFO: up to BPF bytes pushed per cycle, one popped.
// Head reads as 0x00 while empty.
module msu_byte_fifo
  import msu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int BPF   = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(BPF + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic [PW-1:0]    push_n_i,
  input  logic [8*BPF-1:0] push_data_i,
  input  logic             pop_i,
  output logic [CW-1:0]    count_o,
  output logic [7:0]       head_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  assign do_pop = pop_i && (count_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(push_n_i);
      rd_q    <= rd_q + AW'(do_pop);
      count_q <= count_q + CW'(push_n_i)
               - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BPF; i++) begin
      if (!flush_i && (PW'(i) < push_n_i))
        mem_q[wr_q + AW'(i)] <=
          push_data_i[8*i +: 8];
    end
  end

  assign count_o = count_q;
  assign head_o  = (count_q == '0) ? 8'h00
                                   : mem_q[rd_q];

`ifndef SYNTHESIS
  logic [CW:0] fill_next;
  assign fill_next = {1'b0, count_q}
                   + (CW+1)'(push_n_i);
  always @(posedge clk) begin
    if (rst_n && !flush_i)
      assert (fill_next <= (CW+1)'(DEPTH));
  end
`endif

endmodule

// File: rtl/msu_data_stream.sv
// MSU-1 data port: prefetching byte FIFO fed by wide HPS fetches.
// Keeps $2001 reads zero-latency and busy exact after a seek.
module msu_data_stream
  import msu_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 16,
  parameter int PRIME   = 2,
  parameter int ADDR_W  = 32
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               seek_pulse,
  input  logic [ADDR_W-1:0]  seek_addr,
  input  logic               rd_pulse,
  output logic [7:0]         rd_data,
  output logic               data_busy,
  output logic               underrun,
  output logic               fetch_req,
  output logic [ADDR_W-1:0]  fetch_addr,
  input  logic               fetch_ack,
  input  logic [FETCH_W-1:0] fetch_data
);

  localparam int BPF = FETCH_W / 8;
  localparam int SKW = (BPF > 1) ? $clog2(BPF) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = $clog2(BPF + 1);
  localparam logic [ADDR_W-1:0] LOWM =
    ADDR_W'(BPF - 1);

  msu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [SKW-1:0]    skip_q, skip_d;
  logic              req_q, req_d;
  logic              underrun_q, underrun_d;

  logic              flush;
  logic              pop;
  logic [PW-1:0]     push_n;
  logic [FETCH_W-1:0] push_data;
  logic [CW-1:0]     count;
  logic [CW-1:0]     free;

  assign push_data = fetch_data >> {skip_q, 3'b000};
  assign free      = CW'(DEPTH) - count;

  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    req_addr_d  = req_addr_q;
    skip_d      = skip_q;
    req_d       = req_q;
    underrun_d  = underrun_q;
    flush       = 1'b0;
    pop         = 1'b0;
    push_n      = '0;

    if (seek_pulse) begin
      flush       = 1'b1;
      underrun_d  = 1'b0;
      next_addr_d = seek_addr & ~LOWM;
      skip_d      = SKW'(seek_addr & LOWM);
      // An ack landing with the seek closes out the old request.
      if (req_q && !fetch_ack) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_FILL;
        req_d   = 1'b0;
      end
    end else begin
      if (rd_pulse) begin
        if (count != '0) pop = 1'b1;
        else             underrun_d = 1'b1;
      end
      unique case (state_q)
        ST_IDLE: ;
        ST_DRAIN: begin
          if (fetch_ack) begin
            req_d   = 1'b0;
            state_d = ST_FILL;
          end
        end
        ST_FILL, ST_STREAM: begin
          if (req_q) begin
            if (fetch_ack) begin
              push_n      = PW'(BPF) - PW'(skip_q);
              next_addr_d = next_addr_q
                          + ADDR_W'(BPF);
              skip_d      = '0;
              req_d       = 1'b0;
            end
          end else if (free >= CW'(BPF)) begin
            req_d      = 1'b1;
            req_addr_d = next_addr_q;
          end
          if (state_q == ST_FILL
              && count >= CW'(PRIME))
            state_d = ST_STREAM;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      next_addr_q <= '0;
      req_addr_q  <= '0;
      skip_q      <= '0;
      req_q       <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      req_addr_q  <= req_addr_d;
      skip_q      <= skip_d;
      req_q       <= req_d;
      underrun_q  <= underrun_d;
    end
  end

  msu_byte_fifo #(
    .DEPTH (DEPTH),
    .BPF   (BPF)
  ) u_fifo (
    .clk         (CLK),
    .rst_n       (RST_N),
    .flush_i     (flush),
    .push_n_i    (push_n),
    .push_data_i (push_data),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (rd_data)
  );

  assign data_busy  = (state_q == ST_DRAIN)
                   || (state_q == ST_FILL
                       && count < CW'(PRIME));
  assign underrun   = underrun_q;
  assign fetch_req  = req_q;
  assign fetch_addr = req_addr_q;

endmodule

// File: tb/tb_msu_data_stream.sv
// Bench for msu_data_stream: vector table plus
// hand-written fill, unaligned, and reset sequences.
module tb_msu_data_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sk16 = 0, rd16 = 0, ack16 = 0;
  logic [31:0] sa16 = 0;
  logic [15:0] fd16 = 0;
  logic [7:0]  rdd16;
  logic        busy16, und16, req16;
  logic [31:0] fa16;

  logic        sk32 = 0, rd32 = 0, ack32 = 0;
  logic [31:0] sa32 = 0;
  logic [31:0] fd32 = 0;
  logic [7:0]  rdd32;
  logic        busy32, und32, req32;
  logic [31:0] fa32;

  msu_data_stream u16 (
    .CLK (clk), .RST_N (rst_n),
    .seek_pulse (sk16), .seek_addr (sa16),
    .rd_pulse (rd16), .rd_data (rdd16),
    .data_busy (busy16), .underrun (und16),
    .fetch_req (req16), .fetch_addr (fa16),
    .fetch_ack (ack16), .fetch_data (fd16)
  );

  msu_data_stream #(.FETCH_W(32)) u32 (
    .CLK (clk), .RST_N (rst_n),
    .seek_pulse (sk32), .seek_addr (sa32),
    .rd_pulse (rd32), .rd_data (rdd32),
    .data_busy (busy32), .underrun (und32),
    .fetch_req (req32), .fetch_addr (fa32),
    .fetch_ack (ack32), .fetch_data (fd32)
  );

  typedef struct {
    logic        sk;
    logic [31:0] sa;
    logic        rd;
    logic        ack;
    logic [15:0] ad;
    logic [7:0]  e_rd;
    logic        e_busy;
    logic        e_und;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad = 0;

  function automatic vec_t v(
    logic sk, logic [31:0] sa, logic rd,
    logic ack, logic [15:0] ad, logic [7:0] erd,
    logic eb, logic eu, logic er, logic [31:0] ea
  );
    vec_t r;
    r.sk = sk; r.sa = sa; r.rd = rd;
    r.ack = ack; r.ad = ad; r.e_rd = erd;
    r.e_busy = eb; r.e_und = eu;
    r.e_req = er; r.e_addr = ea;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req16(input string nm);
    int n = 0;
    while (!req16 && n < 20) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, req16}, 32'd1);
  endtask

  task automatic wait_req32(input string nm);
    int n = 0;
    while (!req32 && n < 20) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, req32}, 32'd1);
  endtask

  task automatic pulse_ack16(input logic [15:0] d);
    ack16 = 1; fd16 = d;
    tick();
    ack16 = 0; fd16 = 0;
  endtask

  initial begin
    string nm;

    tbl.push_back(v(0,32'h0,  0,0,16'h0,   8'h00,0,0,0,32'h0));
    tbl.push_back(v(1,32'h100,0,0,16'h0,   8'h00,1,0,0,32'h0));
    tbl.push_back(v(0,32'h0,  0,0,16'h0,   8'h00,1,0,1,32'h100));
    tbl.push_back(v(0,32'h0,  0,0,16'h0,   8'h00,1,0,1,32'h100));
    tbl.push_back(v(0,32'h0,  0,1,16'hBBAA,8'hAA,0,0,0,32'h100));
    tbl.push_back(v(0,32'h0,  0,0,16'h0,   8'hAA,0,0,1,32'h102));
    tbl.push_back(v(0,32'h0,  1,0,16'h0,   8'hBB,0,0,1,32'h102));
    tbl.push_back(v(0,32'h0,  1,0,16'h0,   8'h00,0,0,1,32'h102));
    tbl.push_back(v(0,32'h0,  1,0,16'h0,   8'h00,0,1,1,32'h102));
    tbl.push_back(v(0,32'h0,  0,0,16'h0,   8'h00,0,1,1,32'h102));
    tbl.push_back(v(1,32'h300,0,0,16'h0,   8'h00,1,0,1,32'h102));
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(0,32'h0,0,0,16'h0,   8'h00,1,0,1,32'h102));
    tbl.push_back(v(0,32'h0,  0,1,16'hDEAD,8'h00,1,0,0,32'h102));
    tbl.push_back(v(0,32'h0,  0,0,16'h0,   8'h00,1,0,1,32'h300));
    tbl.push_back(v(0,32'h0,  0,1,16'h2211,8'h11,0,0,0,32'h300));
    tbl.push_back(v(1,32'h400,1,0,16'h0,   8'h00,1,0,0,32'h300));
    tbl.push_back(v(0,32'h0,  0,0,16'h0,   8'h00,1,0,1,32'h400));
    tbl.push_back(v(1,32'h500,0,1,16'h9999,8'h00,1,0,0,32'h400));
    tbl.push_back(v(0,32'h0,  0,0,16'h0,   8'h00,1,0,1,32'h500));
    tbl.push_back(v(0,32'h0,  0,1,16'h6655,8'h55,0,0,0,32'h500));
    tbl.push_back(v(0,32'h0,  0,0,16'h0,   8'h55,0,0,1,32'h502));
    tbl.push_back(v(0,32'h0,  1,1,16'h8877,8'h66,0,0,0,32'h502));
    tbl.push_back(v(0,32'h0,  1,0,16'h0,   8'h77,0,0,1,32'h504));
    tbl.push_back(v(0,32'h0,  1,0,16'h0,   8'h88,0,0,1,32'h504));

    tick();
    tick();
    chk("rst.rd",   {24'd0, rdd16}, 32'h0);
    chk("rst.busy", {31'd0, busy16}, 32'h0);
    chk("rst.req",  {31'd0, req16}, 32'h0);
    chk("rst.addr", fa16, 32'h0);
    chk("rst.und",  {31'd0, und32}, 32'h0);
    rst_n = 1;

    foreach (tbl[k]) begin
      sk16 = tbl[k].sk; sa16 = tbl[k].sa;
      rd16 = tbl[k].rd; ack16 = tbl[k].ack;
      fd16 = tbl[k].ad;
      tick();
      sk16 = 0; rd16 = 0; ack16 = 0; fd16 = 0;
      nm = $sformatf("v%0d", k);
      chk({nm, ".rd"}, {24'd0, rdd16},
          {24'd0, tbl[k].e_rd});
      chk({nm, ".busy"}, {31'd0, busy16},
          {31'd0, tbl[k].e_busy});
      chk({nm, ".und"}, {31'd0, und16},
          {31'd0, tbl[k].e_und});
      chk({nm, ".req"}, {31'd0, req16},
          {31'd0, tbl[k].e_req});
      chk({nm, ".addr"}, fa16, tbl[k].e_addr);
    end

    // Unaligned seek on the 32-bit instance.
    sk32 = 1; sa32 = 32'h103;
    tick();
    sk32 = 0;
    wait_req32("u32.req0");
    chk("u32.addr0", fa32, 32'h100);
    ack32 = 1; fd32 = 32'h44332211;
    tick();
    ack32 = 0;
    chk("u32.busy1", {31'd0, busy32}, 32'd1);
    chk("u32.head1", {24'd0, rdd32}, 32'h44);
    wait_req32("u32.req1");
    chk("u32.addr1", fa32, 32'h104);
    ack32 = 1; fd32 = 32'h88776655;
    tick();
    ack32 = 0;
    chk("u32.busy2", {31'd0, busy32}, 32'd0);
    chk("u32.rd0", {24'd0, rdd32}, 32'h44);
    rd32 = 1;
    tick();
    rd32 = 0;
    chk("u32.rd1", {24'd0, rdd32}, 32'h55);

    // Fill to DEPTH with no reads.
    sk16 = 1; sa16 = 32'h0;
    tick();
    sk16 = 0;
    chk("fill.drain", {31'd0, busy16}, 32'd1);
    pulse_ack16(16'hFFFF);
    for (int i = 0; i < 8; i++) begin
      wait_req16($sformatf("fill.req%0d", i));
      chk($sformatf("fill.addr%0d", i), fa16,
          32'(2*i));
      pulse_ack16({8'(2*i+1), 8'(2*i)});
    end
    repeat (5) tick();
    chk("full.req", {31'd0, req16}, 32'd0);
    chk("full.head", {24'd0, rdd16}, 32'h00);
    chk("full.busy", {31'd0, busy16}, 32'd0);
    rd16 = 1;
    tick();
    rd16 = 0;
    repeat (3) tick();
    chk("pop1.req", {31'd0, req16}, 32'd0);
    chk("pop1.head", {24'd0, rdd16}, 32'h01);
    rd16 = 1;
    tick();
    rd16 = 0;
    chk("pop2.head", {24'd0, rdd16}, 32'h02);
    wait_req16("pop2.req");
    chk("pop2.addr", fa16, 32'h10);
    pulse_ack16(16'h1110);

    // Reset while a FILL fetch is outstanding.
    sk16 = 1; sa16 = 32'h40;
    tick();
    sk16 = 0;
    wait_req16("rstf.req");
    chk("rstf.addr", fa16, 32'h40);
    chk("rstf.busy", {31'd0, busy16}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("arst.req", {31'd0, req16}, 32'd0);
    chk("arst.busy", {31'd0, busy16}, 32'd0);
    chk("arst.addr", fa16, 32'h0);
    chk("arst.rd", {24'd0, rdd16}, 32'h0);
    chk("arst.und", {31'd0, und16}, 32'd0);
    tick();
    tick();
    rst_n = 1;
    repeat (6) tick();
    chk("post.req", {31'd0, req16}, 32'd0);
    chk("post.busy", {31'd0, busy16}, 32'd0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/msu_data_stream.md
Name: msu_data_stream

Overview:
Parametrised successor to the MSU-1 data-port path. It replaces the single-byte `msu_data_in`/`msu_data_req` exchange with a prefetching byte FIFO fed by wide HPS fetches. It sits between the MSU register decoder ($2000 status bit 7, $2001 read, $2003 seek) and the HPS data channel. Its job is to keep $2001 reads at zero latency and to make the busy flag exact after a seek.

Parameters:
- DEPTH, 16, FIFO capacity in bytes; power of two, minimum 2*BPF.
- FETCH_W, 16, HPS fetch word width in bits; 8, 16 or 32. BPF = FETCH_W/8 is the number of bytes per fetch.
- PRIME, 2, FIFO byte count that must be reached after a seek before busy clears; range 1..DEPTH.
- ADDR_W, 32, byte address width.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- seek_pulse  in  1  one-cycle strobe, decoder's $2003 write.
- seek_addr  in  ADDR_W  byte address accompanying seek_pulse.
- rd_pulse  in  1  one-cycle strobe, decoder's $2001 read falling edge.
- rd_data  out  8  FIFO head byte, combinational.
- data_busy  out  1  MSU_STATUS bit 7.
- underrun  out  1  sticky flag: a read arrived while the FIFO was empty.
- fetch_req  out  1  request level, held high until fetch_ack.
- fetch_addr  out  ADDR_W  BPF-aligned word address.
- fetch_ack  in  1  one-cycle strobe; fetch_data is valid in the same cycle.
- fetch_data  in  FETCH_W  little-endian; byte 0 is at fetch_addr.

Behaviour:
- Reset values (async assert, sync release):
  - State is IDLE; FIFO is empty.
  - rd_data=0, data_busy=0, underrun=0, fetch_req=0, fetch_addr=0.
- States:
  - IDLE: no stream active.
  - DRAIN: a fetch is outstanding and its data must be discarded.
  - FILL: busy; fetching toward PRIME.
  - STREAM: not busy; prefetching.
- seek_pulse, in any state:
  - Clear the FIFO and underrun.
  - data_busy goes to 1 on the next cycle.
  - Latch next_addr = seek_addr with the low log2(BPF) bits cleared, and skip = seek_addr mod BPF.
  - If fetch_req=1 and fetch_ack has not arrived, go to DRAIN. Otherwise go to FILL.
- DRAIN:
  - Drop fetch_req on the ack.
  - Discard fetch_data.
  - Go to FILL on the following cycle.
  - A further seek in DRAIN only relatches next_addr and skip.
- Fetch issue rule, in FILL and STREAM:
  - Raise fetch_req when no request is outstanding and free space >= BPF.
  - fetch_addr = next_addr. It is stable while fetch_req=1.
  - On fetch_ack: push bytes skip..BPF-1 in ascending order in the ack cycle, increment next_addr by BPF, clear skip to 0, and drop fetch_req.
  - fetch_req may re-assert the cycle after the ack.
- next_addr wraps modulo 2^ADDR_W with no error.
- FILL exits to STREAM on the cycle count >= PRIME becomes true; data_busy falls that same cycle. Busy never re-asserts without a seek.
- Read port:
  - rd_data always equals the FIFO head.
  - rd_pulse with count > 0 pops one byte; the new head is visible the next cycle.
  - rd_pulse with count = 0: no pop, rd_data stays at 0x00, underrun is set.
  - rd_pulse while data_busy=1 still pops if data is present. The decoder is responsible for ignoring the result.
- Simultaneous events:
  - Ack push and rd_pulse pop in the same cycle are both applied.
  - seek_pulse and rd_pulse together: the seek wins and the pop is dropped.
  - seek_pulse and fetch_ack together: the ack completes the old request, its data is discarded, and the block goes to FILL.
- Full: no fetch is issued when free space < BPF. Overflow is impossible by construction; assert this in simulation.
- Reset during an outstanding fetch: fetch_req drops asynchronously. The HPS side must tolerate an abandoned request.

Decomposition:
- Package msu_pkg holds:
  - the state enum (IDLE, DRAIN, FILL, STREAM);
  - MSU_STATUS bit-index constants (DATA_BUSY=7, AUDIO_BUSY=6, REPEAT=5, PLAYING=4, MISSING=3);
  - MSU_REVISION=3'b001;
  - the "S-MSU1" ID byte constants.
- Sub-module msu_byte_fifo(DEPTH):
  - multi-byte push, up to BPF bytes per cycle, with count input;
  - single-byte pop;
  - flush input;
  - count output, zero-padded head output.

Test Plan:
- FETCH_W=16, PRIME=2. Seek to 0x100; HPS returns 0xBBAA at 0x100.
  - busy falls the cycle after the ack.
  - Reads return 0xAA then 0xBB.
  - The next fetch_addr is 0x102.
- Unaligned seek to 0x103 with FETCH_W=32.
  - fetch_addr=0x100; ack data 0x44332211.
  - Only 0x44 is pushed; busy waits for the second word at 0x104.
  - The first read returns 0x44.
- Fill the FIFO to DEPTH=16 with no reads.
  - fetch_req stays low.
  - One 16-bit read pair (two pops) frees space and fetch_req re-asserts.
- Seek while a request is outstanding (ack delayed 5 cycles).
  - Data 0xDEAD is discarded.
  - The next fetch_addr equals the new seek address.
  - The first read returns data from the new address.
- Read on an empty FIFO in STREAM (HPS stalled).
  - rd_data=0x00 and underrun=1.
  - A subsequent seek clears underrun.
- Assert RST_N low mid-FILL with fetch_req=1.
  - All outputs return to reset values immediately.
  - After release, no fetch is issued until a seek.
